// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: pipelined main control decoder with a valid/ready handshake,
// stall, flush, illegal-opcode detection and a trap/acknowledge state machine.
// Optional feature macro: CTRL_DECODE_JUMP_EN (decodes jal 1101111 as legal).
module ctrl_decode_pipe #(
  parameter int PIPE_DEPTH = 2,
  parameter int ILL_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           Op,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 RegWrite,
  output logic [1:0]           ImmSrc,
  output logic                 ALUSrc,
  output logic                 MemWrite,
  output logic [1:0]           ResultSrc,
  output logic                 Branch,
  output logic                 Jump,
  output logic [1:0]           ALUOp,
  output logic                 illegal,
  output logic                 trap,
  input  logic                 trap_ack,
  output logic [ILL_CNT_W-1:0] ill_count
);

  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {RUN, TRAP} state_t;

  // Opcode -> control bundle; anything not listed is flagged illegal with
  // every control field left at 0 so a retired illegal entry is harmless.
  function automatic ctrl_t decode(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      7'b0000011: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = 2'b01; end
      7'b0100011: begin c.imm_src = 2'b01; c.alu_src = 1'b1; c.mem_write = 1'b1; end
      7'b0110011: begin c.reg_write = 1'b1; c.alu_op = 2'b10; end
      7'b0010011: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 2'b10; end
      7'b1100011: begin c.imm_src = 2'b10; c.branch = 1'b1; c.alu_op = 2'b01; end
`ifdef CTRL_DECODE_JUMP_EN
      7'b1101111: begin
        c.reg_write = 1'b1; c.imm_src = 2'b11; c.result_src = 2'b10; c.jump = 1'b1;
      end
`endif
      default:    c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  localparam int LAST = PIPE_DEPTH - 1;

  ctrl_t [PIPE_DEPTH-1:0] stage_q;
  logic  [PIPE_DEPTH-1:0] vld_pipe;
  state_t                 state;
  ctrl_t                  out_c;
  logic                   advance;
  logic                   accept;
  logic                   retire_ill;

  assign out_c      = stage_q[LAST];
  assign out_valid  = vld_pipe[LAST];
  assign advance    = out_ready | ~out_valid;
  assign in_ready   = advance & (state == RUN) & ~flush;
  assign accept     = in_valid & in_ready;
  assign retire_ill = out_valid & out_ready & out_c.illegal & (state == RUN);

  // Valid bits: whole pipe shifts or whole pipe holds; flush and trap entry
  // discard everything in flight (the retiring entry has already left).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
    end else if (flush || retire_ill) begin
      vld_pipe <= '0;
    end else if (advance) begin
      vld_pipe[0] <= accept;
      for (int i = 1; i < PIPE_DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Control bundles follow the valid bits; bubbles carry an all-zero bundle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else if (advance) begin
      stage_q[0] <= accept ? decode(Op) : ctrl_t'('0);
      for (int i = 1; i < PIPE_DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Trap FSM with registered trap pulse and saturating illegal counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      trap      <= 1'b0;
      ill_count <= '0;
    end else begin
      trap <= retire_ill;
      case (state)
        RUN: if (retire_ill) begin
          state <= TRAP;
          if (ill_count != {ILL_CNT_W{1'b1}}) ill_count <= ill_count + 1'b1;
        end
        TRAP: if (trap_ack) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign RegWrite  = out_c.reg_write;
  assign ImmSrc    = out_c.imm_src;
  assign ALUSrc    = out_c.alu_src;
  assign MemWrite  = out_c.mem_write;
  assign ResultSrc = out_c.result_src;
  assign Branch    = out_c.branch;
  // Without the jump feature the decoder never sets this field, so the
  // register bit is constant 0 and Jump is effectively tied low.
  assign Jump      = out_c.jump;
  assign ALUOp     = out_c.alu_op;
  assign illegal   = out_c.illegal;

endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Parametrised, pipelined successor to the single-cycle main control decoder. It decodes the 7-bit opcode into datapath control signals through `PIPE_DEPTH` registered stages with a valid/ready handshake, stall and flush. It also detects illegal opcodes and holds a trap state machine until software acknowledges. It sits between instruction fetch/issue and the execute-stage control register.

## Interface

Parameters:
- `PIPE_DEPTH`, default 2, number of registered stages (1..4).
- `ILL_CNT_W`, default 8, width of the illegal-opcode counter.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: opcode on `Op` is valid.
- `in_ready` out 1: block accepts `Op` this cycle.
- `Op` in 7: instruction opcode.
- `flush` in 1: synchronous kill of all in-flight entries.
- `out_valid` out 1: control bundle valid.
- `out_ready` in 1: consumer accepts bundle.
- `RegWrite` out 1: register write enable.
- `ImmSrc` out 2: immediate type.
- `ALUSrc` out 1: ALU source select.
- `MemWrite` out 1: memory write enable.
- `ResultSrc` out 2: result mux select (00 ALU, 01 mem, 10 PC+4).
- `Branch` out 1: branch instruction.
- `Jump` out 1: jump instruction.
- `ALUOp` out 2: ALU decoder operation class.
- `illegal` out 1: output entry carries an illegal opcode.
- `trap` out 1: one-cycle pulse, illegal entry retired.
- `trap_ack` in 1: leave TRAP state.
- `ill_count` out `ILL_CNT_W`: saturating count of retired illegal opcodes.

## Operation

- Decode, with unlisted fields 0:
  - 0000011 load: RegWrite=1, ALUSrc=1, ResultSrc=01.
  - 0100011 store: ImmSrc=01, ALUSrc=1, MemWrite=1.
  - 0110011 R-type: RegWrite=1, ALUOp=10.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, ALUOp=10.
  - 1100011 branch: ImmSrc=10, Branch=1, ALUOp=01.
  - 1101111 jal: only with the configuration macro (see Configuration).
  - Any other opcode: illegal=1, all control fields 0.
- Pipeline: `PIPE_DEPTH` stages, each holding a valid bit and a control bundle. The output ports are the last stage.
- `advance = out_ready | ~out_valid`. When `advance` is set, all stages shift one place. Otherwise all stages hold (full-pipe stall).
- Bubbles propagate as invalid entries.
- `in_ready = advance & (state==RUN) & ~flush`. The first stage loads a valid entry only on `in_valid & in_ready`, else a bubble.
- `flush`: at the edge, all valid bits clear. An output handshake occurring in the same cycle still counts.
- FSM states:
  - RUN: moves to TRAP when `out_valid & out_ready & illegal` (illegal retire).
  - TRAP: `in_ready=0`. All valid bits clear on entry, so younger entries are discarded. Moves to RUN when `trap_ack=1`.
- `trap` is registered: high for exactly one cycle after the illegal-retire edge.
- `ill_count` increments on each illegal retire and saturates at all-ones.
- `trap_ack` in RUN is ignored. `flush` does not change FSM state.

## Timing

- Reset: all valid bits 0; every control output, `illegal`, `trap` and `ill_count` equal 0; state RUN. `in_ready` reflects `advance` immediately after reset.
- Latency: an opcode accepted at edge N appears on outputs after edge N+PIPE_DEPTH-1, with no stall and the first stage counted as edge N.
- Throughput: one per cycle with `out_ready` held high.
- Reset mid-operation clears everything asynchronously, including the TRAP state.
- Outputs change only on clock edges. There is no combinational path from `Op` to outputs.
- There is a combinational path from `out_ready` to `in_ready`.

## Configuration

- Macro `CTRL_DECODE_JUMP_EN`.
- Defined: opcode 1101111 decodes RegWrite=1, ImmSrc=11, ResultSrc=10, Jump=1, legal.
- Undefined: 1101111 is illegal, `Jump` is tied 0, and ImmSrc=11 and ResultSrc=10 never occur.

## Test plan

- Reset release, `PIPE_DEPTH=2`, stream 0000011, 0100011, 0110011, 1100011 with `out_ready=1` -> bundles appear in order starting 2 cycles after the first accept, with values per the decode list.
- `out_ready=0` for 5 cycles with the pipe full -> outputs stable, `in_ready=0`. Release -> no entry lost or duplicated.
- Send 0110011 then 1111111 -> R-type retires normally. The illegal entry retires with all controls 0, then `trap` pulses 1 cycle, `ill_count`=1, `in_ready=0` until `trap_ack`, and younger entries are dropped.
- Assert `flush` with 2 valid entries in flight -> `out_valid`=0 next cycle and nothing from before the flush retires. An input offered in the flush cycle is not accepted.
- 1101111 with `CTRL_DECODE_JUMP_EN` -> Jump=1, ImmSrc=11, ResultSrc=10. Without the macro -> illegal=1, trap fires.
- `ILL_CNT_W=2`, retire 5 illegal opcodes with `trap_ack` after each -> `ill_count` saturates at 3. Assert `rst` low while in TRAP -> RUN with all outputs 0.
